// File: rtl/branch.sv
// RI16-form branch unit: decodes relative/absolute/conditional branches, produces the
// next PC and an optional link write, registered with one cycle of latency.
// Build option: define BRANCH_ABS_EN to decode the absolute forms bra and brasl.
module branch (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:127] rt,
    input  logic [0:6]   addr_rt,
    input  logic [0:8]   opcode9,
    input  logic [0:15]  immediate16,
    input  logic [0:31]  PCin,
    output logic [0:138] pipe,
    output logic [0:32]  PCpipe
);

    // No handshake: one instruction is accepted on every rising edge and its result
    // is visible from just after that edge until the next one.

    localparam logic [0:8] OP_BR    = 9'b001100100;
    localparam logic [0:8] OP_BRSL  = 9'b001100110;
    localparam logic [0:8] OP_BRA   = 9'b001100000;
    localparam logic [0:8] OP_BRASL = 9'b001100010;
    localparam logic [0:8] OP_BRZ   = 9'b001000000;
    localparam logic [0:8] OP_BRNZ  = 9'b001000010;
    localparam logic [0:8] OP_BRHZ  = 9'b001000100;
    localparam logic [0:8] OP_BRHNZ = 9'b001000110;

    localparam logic [0:2] LATENCY_TAG = 3'd4;

    typedef enum logic [2:0] {
        COND_ALWAYS,
        COND_WORD_ZERO,
        COND_WORD_NONZERO,
        COND_HALF_ZERO,
        COND_HALF_NONZERO
    } cond_e;

    typedef struct packed {
        logic  known;
        logic  link;
        logic  absolute;
        cond_e cond;
    } decode_t;

    decode_t       dec;
    logic [0:31]   off;
    logic [0:31]   seq_pc;
    logic [0:31]   target_raw;
    logic [0:31]   target;
    logic          word_zero;
    logic          half_zero;
    logic          taken;
    logic [0:138]  pipe_next;
    logic [0:32]   pc_next;
    logic          unused_rt;

    // Only the preferred word is ever inspected.
    assign unused_rt = ^rt[32:127];

    always_comb begin
        dec = '{known: 1'b0, link: 1'b0, absolute: 1'b0, cond: COND_ALWAYS};
        case (opcode9)
            OP_BR:    dec = '{known: 1'b1, link: 1'b0, absolute: 1'b0, cond: COND_ALWAYS};
            OP_BRSL:  dec = '{known: 1'b1, link: 1'b1, absolute: 1'b0, cond: COND_ALWAYS};
`ifdef BRANCH_ABS_EN
            OP_BRA:   dec = '{known: 1'b1, link: 1'b0, absolute: 1'b1, cond: COND_ALWAYS};
            OP_BRASL: dec = '{known: 1'b1, link: 1'b1, absolute: 1'b1, cond: COND_ALWAYS};
`endif
            OP_BRZ:   dec = '{known: 1'b1, link: 1'b0, absolute: 1'b0, cond: COND_WORD_ZERO};
            OP_BRNZ:  dec = '{known: 1'b1, link: 1'b0, absolute: 1'b0, cond: COND_WORD_NONZERO};
            OP_BRHZ:  dec = '{known: 1'b1, link: 1'b0, absolute: 1'b0, cond: COND_HALF_ZERO};
            OP_BRHNZ: dec = '{known: 1'b1, link: 1'b0, absolute: 1'b0, cond: COND_HALF_NONZERO};
            default:  dec = '{known: 1'b0, link: 1'b0, absolute: 1'b0, cond: COND_ALWAYS};
        endcase
    end

    always_comb begin
        off        = {{14{immediate16[0]}}, immediate16, 2'b00};
        seq_pc     = PCin + 32'd4;
        target_raw = dec.absolute ? off : (PCin + off);
        // An unaligned PCin can leave low bits set in a relative target.
        target     = {target_raw[0:29], 2'b00};
        word_zero  = (rt[0:31] == 32'd0);
        half_zero  = (rt[16:31] == 16'd0);

        case (dec.cond)
            COND_ALWAYS:       taken = 1'b1;
            COND_WORD_ZERO:    taken = word_zero;
            COND_WORD_NONZERO: taken = !word_zero;
            COND_HALF_ZERO:    taken = half_zero;
            COND_HALF_NONZERO: taken = !half_zero;
            default:           taken = 1'b0;
        endcase
        taken = taken && dec.known;
    end

    always_comb begin
        pipe_next = '0;
        pc_next   = {seq_pc, 1'b0};
        if (dec.known) begin
            pipe_next[128:130] = LATENCY_TAG;
            pipe_next[132:138] = addr_rt;
            if (dec.link) begin
                pipe_next[0:31] = seq_pc;
                pipe_next[131]  = 1'b1;
            end
            if (taken) begin
                pc_next = {target, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe   <= '0;
            PCpipe <= '0;
        end else begin
            pipe   <= pipe_next;
            PCpipe <= pc_next;
        end
    end

endmodule

// File: tb/tb_branch.sv
// Bench for the branch unit: directed vector table, reset sequences, and random
// instructions checked against an arithmetic reference model.
module tb_branch;

    logic         clk;
    logic         reset;
    logic [0:127] rt;
    logic [0:6]   addr_rt;
    logic [0:8]   opcode9;
    logic [0:15]  immediate16;
    logic [0:31]  PCin;
    logic [0:138] pipe;
    logic [0:32]  PCpipe;

    int checks = 0;
    int errors = 0;

    logic [171:0] exp_q[$];

    typedef struct packed {
        logic [0:8]   op;
        logic [0:15]  imm;
        logic [0:31]  pc;
        logic [0:127] rtv;
        logic [0:6]   addr;
        logic [0:138] exp_pipe;
        logic [0:32]  exp_pc;
    } vec_t;

    vec_t vecs[$];

    branch dut (
        .clk         (clk),
        .reset       (reset),
        .rt          (rt),
        .addr_rt     (addr_rt),
        .opcode9     (opcode9),
        .immediate16 (immediate16),
        .PCin        (PCin),
        .pipe        (pipe),
        .PCpipe      (PCpipe)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic drive(input logic [0:8] op, input logic [0:15] imm, input logic [0:31] pc,
                         input logic [0:127] rtv, input logic [0:6] addr);
        opcode9     = op;
        immediate16 = imm;
        PCin        = pc;
        rt          = rtv;
        addr_rt     = addr;
    endtask

    task automatic add_vec(input logic [0:8] op, input logic [0:15] imm, input logic [0:31] pc,
                           input logic [0:127] rtv, input logic [0:6] addr,
                           input logic [0:138] ep, input logic [0:32] epc);
        vec_t v;
        v.op = op; v.imm = imm; v.pc = pc; v.rtv = rtv; v.addr = addr;
        v.exp_pipe = ep; v.exp_pc = epc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [171:0] act, input logic [171:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pipe=%h pc=%h expected pipe=%h pc=%h",
                     name, act[171:33], act[32:0], exp[171:33], exp[32:0]);
        end
    endtask

    // reference model, straight from the instruction descriptions
    function automatic logic [171:0] model(input logic [0:8] op, input logic [0:15] imm,
                                           input logic [0:31] pc, input logic [0:127] rtv,
                                           input logic [0:6] addr);
        bit known = 1, link = 0, absolute = 0, taken = 1;
        logic [31:0] offset, target, next_seq;
        logic [31:0] word0;
        logic [15:0] half1;
        logic [127:0] data;
        word0 = rtv[0:31];
        half1 = rtv[16:31];
        case (op)
            9'b001100100: ;
            9'b001100110: link = 1;
`ifdef BRANCH_ABS_EN
            9'b001100000: absolute = 1;
            9'b001100010: begin absolute = 1; link = 1; end
`endif
            9'b001000000: taken = (word0 == 0);
            9'b001000010: taken = (word0 != 0);
            9'b001000100: taken = (half1 == 0);
            9'b001000110: taken = (half1 != 0);
            default:      known = 0;
        endcase
        next_seq = pc + 32'd4;
        if (!known) return {139'd0, next_seq, 1'b0};
        offset = 32'($signed(imm)) * 32'd4;
        target = absolute ? offset : pc + offset;
        target = target - (target % 4);
        data   = link ? {next_seq, 96'd0} : 128'd0;
        return {data, 3'd4, 1'(link), addr, (taken ? target : next_seq), 1'(taken)};
    endfunction

    logic [0:127] rt_a;
    logic [0:127] rt_h;
    logic [0:127] rt_w0;

    initial begin
        reset = 1'b0;
        drive(9'd0, 16'd0, 32'd0, 128'd0, 7'd0);

        rt_a  = {32'h3727C5AC, 96'h0};
        rt_h  = {32'h12340000, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
        rt_w0 = {32'h0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF};

        // br / brsl / brz / brnz / brhz / wrap scenarios and edge cases
        add_vec(9'b001100100, 16'h0001, 32'h4, 128'd0, 7'd5,
                {128'h0, 3'd4, 1'b0, 7'd5}, {32'h00000008, 1'b1});
        add_vec(9'b001100110, 16'h0002, 32'h8, 128'd0, 7'd1,
                {32'h0000000C, 96'h0, 3'd4, 1'b1, 7'd1}, {32'h00000010, 1'b1});
        add_vec(9'b001000000, 16'h0003, 32'hC, rt_a, 7'd2,
                {128'h0, 3'd4, 1'b0, 7'd2}, {32'h00000010, 1'b0});
        add_vec(9'b001000010, 16'h0004, 32'h10, rt_a, 7'd3,
                {128'h0, 3'd4, 1'b0, 7'd3}, {32'h00000020, 1'b1});
        add_vec(9'b001000100, 16'hFFFF, 32'h100, rt_h, 7'd4,
                {128'h0, 3'd4, 1'b0, 7'd4}, {32'h000000FC, 1'b1});
        add_vec(9'b001100100, 16'hFFFF, 32'h0, 128'd0, 7'd6,
                {128'h0, 3'd4, 1'b0, 7'd6}, {32'hFFFFFFFC, 1'b1});
        add_vec(9'b001000110, 16'h0010, 32'h200, rt_h, 7'd7,
                {128'h0, 3'd4, 1'b0, 7'd7}, {32'h00000204, 1'b0});
        add_vec(9'b111111111, 16'h0010, 32'h20, rt_a, 7'd9,
                139'd0, {32'h00000024, 1'b0});
        add_vec(9'b001100100, 16'h0001, 32'h7, 128'd0, 7'd10,
                {128'h0, 3'd4, 1'b0, 7'd10}, {32'h00000008, 1'b1});
        add_vec(9'b001000010, 16'h0040, 32'hFFFFFFFE, rt_w0, 7'd11,
                {128'h0, 3'd4, 1'b0, 7'd11}, {32'h00000002, 1'b0});
        add_vec(9'b001000000, 16'h0002, 32'h200, rt_w0, 7'd12,
                {128'h0, 3'd4, 1'b0, 7'd12}, {32'h00000208, 1'b1});
`ifdef BRANCH_ABS_EN
        add_vec(9'b001100000, 16'h0010, 32'h1000, 128'd0, 7'd13,
                {128'h0, 3'd4, 1'b0, 7'd13}, {32'h00000040, 1'b1});
        add_vec(9'b001100010, 16'h8000, 32'h50, 128'd0, 7'h7F,
                {32'h00000054, 96'h0, 3'd4, 1'b1, 7'h7F}, {32'hFFFE0000, 1'b1});
`else
        add_vec(9'b001100000, 16'h0010, 32'h1000, 128'd0, 7'd13,
                139'd0, {32'h00001004, 1'b0});
        add_vec(9'b001100010, 16'h8000, 32'h50, 128'd0, 7'h7F,
                139'd0, {32'h00000054, 1'b0});
`endif

        // reset state, held across edges
        #12;
        check("reset_initial", {pipe, PCpipe}, 172'd0);
        drive(9'b001100100, 16'h0001, 32'h4, 128'd0, 7'd5);
        @(posedge clk); #1;
        check("reset_held_edge", {pipe, PCpipe}, 172'd0);
        @(negedge clk);
        reset = 1'b1;

        // directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].imm, vecs[i].pc, vecs[i].rtv, vecs[i].addr);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {pipe, PCpipe}, {vecs[i].exp_pipe, vecs[i].exp_pc});
        end

        // mid-operation reset discards the pending result
        drive(9'b001100110, 16'h0002, 32'h8, 128'd0, 7'd1);
        @(posedge clk); #1;
        check("pre_reset_brsl", {pipe, PCpipe},
              {32'h0000000C, 96'h0, 3'd4, 1'b1, 7'd1, 32'h00000010, 1'b1});
        drive(9'b001100100, 16'h0004, 32'h40, 128'd0, 7'd2);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", {pipe, PCpipe}, 172'd0);
        @(posedge clk); #1;
        check("reset_discard", {pipe, PCpipe}, 172'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(9'h1FF, 16'h0000, 32'h30, 128'd0, 7'd3);
        #1;
        check("reset_release_no_edge", {pipe, PCpipe}, 172'd0);
        @(posedge clk); #1;
        check("post_reset_unknown_op", {pipe, PCpipe}, {139'd0, 32'h00000034, 1'b0});

        // random instructions against the model, scoreboarded
        for (int i = 0; i < 400; i++) begin
            logic [0:8]   op;
            logic [0:127] rv;
            logic [0:6]   ad;
            logic [0:15]  im;
            logic [0:31]  pc;
            logic [171:0] exp;
            case ($urandom_range(0, 9))
                0: op = 9'b001100100;
                1: op = 9'b001100110;
                2: op = 9'b001100000;
                3: op = 9'b001100010;
                4: op = 9'b001000000;
                5: op = 9'b001000010;
                6: op = 9'b001000100;
                7: op = 9'b001000110;
                default: op = 9'($urandom);
            endcase
            rv = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rv[0:31] = 32'd0;
                1: rv[16:31] = 16'd0;
                default: ;
            endcase
            im = 16'($urandom);
            pc = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15))) : $urandom;
            ad = 7'($urandom);
            drive(op, im, pc, rv, ad);
            exp_q.push_back(model(op, im, pc, rv, ad));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            check($sformatf("rand%0d", i), {pipe, PCpipe}, exp);
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch.md
BRANCH -- requirements
Module: branch

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have: rt  in  128 [0:127]  RT register operand; word0 = rt[0:31] is the preferred slot, halfword1 = rt[16:31].
REQ-004 SHALL have: addr_rt  in  7 [0:6]  RT register number, used as the link-write target.
REQ-005 SHALL have: opcode9  in  9 [0:8]  RI16-form opcode.
REQ-006 SHALL have: immediate16  in  16 [0:15]  signed word offset.
REQ-007 SHALL have: PCin  in  32 [0:31]  address of the current instruction.
REQ-008 SHALL have: pipe  out  139 [0:138]  bits [0:127] write data, [128:130] latency tag, [131] write enable, [132:138] target register.
REQ-009 SHALL have: PCpipe  out  33 [0:32]  bits [0:31] next PC, [32] taken flag.

Function
REQ-010 SHALL decode the following opcodes. br 001100100 and brsl 001100110 are relative, unconditional. bra 001100000 and brasl 001100010 are absolute, unconditional. brz 001000000 and brnz 001000010 test word0. brhz 001000100 and brhnz 001000110 test halfword1.
REQ-011 SHALL form off = sign_extend(immediate16) << 2, a 32-bit value.
REQ-012 SHALL compute the relative target as (PCin + off) mod 2^32 and the absolute target as off.
REQ-013 SHALL force target bits [30:31] to 0.
REQ-014 Condition: brz is taken if rt[0:31]==0; brnz if !=0; brhz if rt[16:31]==0; brhnz if !=0; unconditional forms are always taken.
REQ-015 Taken: PCpipe[0:31] SHALL be the target and PCpipe[32] SHALL be 1.
REQ-016 Not taken: PCpipe[0:31] SHALL be (PCin+4) mod 2^32 and PCpipe[32] SHALL be 0.
REQ-017 brsl and brasl SHALL set pipe[0:31] = (PCin+4) mod 2^32, pipe[32:127] = 0, pipe[131] = 1, and pipe[132:138] = addr_rt.
REQ-018 All other decoded ops SHALL set pipe[0:127] = 0, pipe[131] = 0, and pipe[132:138] = addr_rt.
REQ-019 pipe[128:130] SHALL be 3'd4 for every decoded op.
REQ-020 An unrecognised opcode SHALL produce pipe = 0 and PCpipe = {PCin+4, 0}.
REQ-021 Latency SHALL be 1 cycle: inputs are sampled on rising edge N, and outputs are valid after edge N and held until edge N+1.
REQ-022 The unit SHALL accept one instruction per cycle, with no stall and no handshake.
REQ-023 PC arithmetic SHALL wrap modulo 2^32 with no overflow flag.

Reset
REQ-024 While reset==0, pipe SHALL be 0 and PCpipe SHALL be 0, asynchronously and regardless of clk.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight result; the first valid output comes one rising edge after reset deasserts.

Configuration
REQ-026 Macro BRANCH_ABS_EN defined: bra and brasl SHALL be decoded per REQ-010..019.
REQ-027 Macro BRANCH_ABS_EN undefined: bra and brasl SHALL be treated as unrecognised opcodes per REQ-020.

Verification
REQ-028 Scenario br: PCin=4, imm=1 -> after one edge, PCpipe={0x00000008,1} and pipe[131]=0.
REQ-029 Scenario brsl: PCin=8, imm=2, addr_rt=1 -> PCpipe={0x00000010,1}, pipe[0:31]=0x0000000C, pipe[131]=1, pipe[132:138]=1.
REQ-030 Scenario brz / brnz: rt[0:31]=0x3727C5AC. brz with PCin=12, imm=3 -> PCpipe={0x00000010,0}. brnz with PCin=16, imm=4 -> PCpipe={0x00000020,1}.
REQ-031 Scenario brhz: rt[16:31]=0, rt[0:15]=0x1234, PCin=0x100, imm=0xFFFF -> PCpipe={0x000000FC,1}.
REQ-032 Scenario wrap: br with PCin=0, imm=0xFFFF -> PCpipe={0xFFFFFFFC,1}.
REQ-033 Scenario reset: drive reset=0 between clock edges while an instruction is pending -> pipe=0 and PCpipe=0 immediately; an unrecognised opcode gives PCpipe={PCin+4,0}.
